neuron_layer_sequencer: RTL

Controller that sequences one pass of a layer of `neuron_inputlayer` datapaths. It accepts a start handshake from the upstream layer and drives the shared `counter` bus across all neurons from 0 to `COUNTER_END`. It then waits out the multiplier/adder/activation pipeline latency, pulses `capture` when neuron outputs are final, and presents the result to the next layer through a valid/ready handshake. Back-to-back passes, abort, and a completed-pass count are supported.

---
 rtl/neuron_layer_sequencer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/neuron_layer_sequencer.sv
// neuron_layer_sequencer: sequences one pass of a neuron_inputlayer array.
// Sweeps the shared counter bus 0..COUNTER_END, waits out the neuron
// pipeline latency, strobes capture once the outputs are final, then holds
// the result for the next layer on a valid/ready handshake.
module neuron_layer_sequencer #(
    parameter int unsigned COUNTER_END = 783,
    parameter int unsigned PIPE_LAT    = 2,
    parameter int unsigned PASS_BITS   = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic                 act_sel_in,
    input  logic                 abort,
    output logic                 activation_function,
    output logic [31:0]          counter,
    output logic                 busy,
    output logic                 capture,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PASS_BITS-1:0] pass_count
);

    localparam logic [31:0] CNT_END = 32'(COUNTER_END);
    localparam logic [3:0]  LAT     = 4'(PIPE_LAT);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        HOLD
    } state_t;

    state_t     state;
    logic [3:0] drain_cnt;
    logic       accept;

    // Start is accepted when idle, or when the held result is leaving this cycle.
    always_comb begin
        start_ready = 1'b0;
        if (!abort) begin
            start_ready = (state == IDLE) || ((state == HOLD) && out_ready);
        end
        accept = start_valid && start_ready;
    end

    // Pass sequencing FSM with all outputs registered.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state               <= IDLE;
            counter             <= '0;
            activation_function <= 1'b0;
            capture             <= 1'b0;
            out_valid           <= 1'b0;
            busy                <= 1'b0;
            pass_count          <= '0;
            drain_cnt           <= '0;
        end else if (abort) begin
            state     <= IDLE;
            counter   <= '0;
            capture   <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            drain_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    counter   <= '0;
                    capture   <= 1'b0;
                    out_valid <= 1'b0;
                    if (accept) begin
                        activation_function <= act_sel_in;
                        busy                <= 1'b1;
                        // Degenerate single-value pass with no latency: outputs final at once.
                        capture             <= (LAT == 4'd0) && (CNT_END == 32'd0);
                        state               <= RUN;
                    end
                end

                RUN: begin
                    if (counter == CNT_END) begin
                        if (LAT == 4'd0) begin
                            state     <= HOLD;
                            out_valid <= 1'b1;
                            busy      <= 1'b0;
                            capture   <= 1'b0;
                        end else begin
                            state     <= DRAIN;
                            drain_cnt <= 4'd1;
                            capture   <= (LAT == 4'd1);
                        end
                    end else begin
                        counter <= counter + 32'd1;
                        // With no pipeline, outputs are final on the last counter value.
                        capture <= (LAT == 4'd0) && ((counter + 32'd1) == CNT_END);
                    end
                end

                DRAIN: begin
                    if (drain_cnt == LAT) begin
                        state     <= HOLD;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        capture   <= 1'b0;
                        drain_cnt <= '0;
                    end else begin
                        drain_cnt <= drain_cnt + 4'd1;
                        capture   <= ((drain_cnt + 4'd1) == LAT);
                    end
                end

                HOLD: begin
                    capture <= 1'b0;
                    if (out_ready) begin
                        pass_count <= pass_count + PASS_BITS'(1);
                        out_valid  <= 1'b0;
                        counter    <= '0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                        if (accept) begin
                            activation_function <= act_sel_in;
                            busy                <= 1'b1;
                            capture             <= (LAT == 4'd0) && (CNT_END == 32'd0);
                            state               <= RUN;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
